// File: rtl/contrast_stretch_stream_if.sv
// Pixel stream bundle: frame/line syncs, pixel strobe and a packed multi-channel pixel word.
// The producer drives through the master modport; the consumer reads through the slave modport.
interface contrast_stretch_stream_if #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1
);
    logic                         vsync;
    logic                         hsync;
    logic                         valid;
    logic [CHANNELS*DATA_W-1:0]   data;

    modport master (output vsync, hsync, valid, data);
    modport slave  (input  vsync, hsync, valid, data);
endinterface

// File: rtl/contrast_stretch_stream.sv
// Programmable per-channel linear contrast stretch with per-frame min/max statistics.
// Gains are computed by one shared serial divider during vertical blanking.
module contrast_stretch_stream #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int FRAC     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [1:0]                   cfg_mode,
    input  logic [DATA_W-1:0]            cfg_min,
    input  logic [DATA_W-1:0]            cfg_max,
    contrast_stretch_stream_if.slave     pre,
    contrast_stretch_stream_if.master    post,
    output logic [CHANNELS*DATA_W-1:0]   stat_min,
    output logic [CHANNELS*DATA_W-1:0]   stat_max,
    output logic                         gain_busy,
    output logic                         frame_skip
);
    localparam int GW  = DATA_W + FRAC;
    localparam int PW  = DATA_W + GW;
    localparam int SW  = 2 * DATA_W;
    localparam int CW  = $clog2(GW);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [GW-1:0] GAIN_ONE = GW'(1) << FRAC;
    localparam logic [GW-1:0] DIVIDEND = {{DATA_W{1'b1}}, {FRAC{1'b0}}};
    localparam logic [CW-1:0] LAST_BIT = CW'(GW - 1);
    localparam logic [CHW-1:0] LAST_CH = CHW'(CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV,
        ST_COMMIT
    } state_t;

    logic                        vsync_d_reg;
    logic                        vs_rise;
    logic [2:0]                  vs_pipe_reg;
    logic [2:0]                  hs_pipe_reg;
    logic [2:0]                  vld_pipe_reg;
    logic [CHANNELS*DATA_W-1:0]  run_min_flat;
    logic [CHANNELS*DATA_W-1:0]  run_max_flat;
    logic [CHANNELS*DATA_W-1:0]  data_out;

    state_t                      state_reg;
    logic                        busy_reg;
    logic                        skip_pulse_reg;
    logic                        skip_flag_reg;
    logic [CHW-1:0]              ch_reg;
    logic [CW-1:0]               cnt_reg;
    logic [DATA_W-1:0]           rem_reg;
    logic [GW-1:0]               quo_reg;
    logic [GW-1:0]               dvd_reg;

    logic [DATA_W-1:0]           win_min_reg    [CHANNELS];
    logic [DATA_W-1:0]           win_max_reg    [CHANNELS];
    logic [DATA_W-1:0]           shadow_min_reg [CHANNELS];
    logic [GW-1:0]               shadow_gain_reg[CHANNELS];
    logic [DATA_W-1:0]           act_min_reg    [CHANNELS];
    logic [GW-1:0]               act_gain_reg   [CHANNELS];

    logic [DATA_W-1:0]           cur_min;
    logic [DATA_W-1:0]           cur_max;
    logic                        cur_ident;
    logic [DATA_W-1:0]           divisor;
    logic [DATA_W:0]             rem_sh;
    logic                        ge;
    logic [DATA_W-1:0]           rem_nx;
    logic [GW-1:0]               quo_nx;
    logic [GW-1:0]               gain_ceil;

    assign vs_rise = pre.vsync & ~vsync_d_reg;

    // Sync delay line matched to the three datapath stages
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d_reg  <= 1'b0;
            vs_pipe_reg  <= '0;
            hs_pipe_reg  <= '0;
            vld_pipe_reg <= '0;
        end else begin
            vsync_d_reg  <= pre.vsync;
            vs_pipe_reg  <= {vs_pipe_reg[1:0], pre.vsync};
            hs_pipe_reg  <= {hs_pipe_reg[1:0], pre.hsync};
            vld_pipe_reg <= {vld_pipe_reg[1:0], pre.valid};
        end
    end

    assign post.vsync = vs_pipe_reg[2];
    assign post.hsync = hs_pipe_reg[2];
    assign post.valid = vld_pipe_reg[2];
    assign post.data  = data_out;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [DATA_W-1:0] pix;
            logic [DATA_W-1:0] run_min_reg;
            logic [DATA_W-1:0] run_max_reg;
            logic [DATA_W-1:0] stat_min_reg;
            logic [DATA_W-1:0] stat_max_reg;
            logic [DATA_W-1:0] d_reg;
            logic [PW-1:0]     p_reg;
            logic [DATA_W-1:0] out_reg;
            logic [SW-1:0]     shifted;

            assign pix = pre.data[gi*DATA_W +: DATA_W];

            // A pixel coinciding with the vsync rise belongs to the new frame
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    run_min_reg  <= '1;
                    run_max_reg  <= '0;
                    stat_min_reg <= '0;
                    stat_max_reg <= '0;
                end else if (vs_rise) begin
                    stat_min_reg <= run_min_reg;
                    stat_max_reg <= run_max_reg;
                    run_min_reg  <= pre.valid ? pix : '1;
                    run_max_reg  <= pre.valid ? pix : '0;
                end else if (pre.valid) begin
                    if (pix < run_min_reg) run_min_reg <= pix;
                    if (pix > run_max_reg) run_max_reg <= pix;
                end
            end

            assign shifted = SW'(p_reg >> FRAC);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d_reg   <= '0;
                    p_reg   <= '0;
                    out_reg <= '0;
                end else begin
                    d_reg   <= (pix > act_min_reg[gi]) ? pix - act_min_reg[gi] : '0;
                    p_reg   <= {{GW{1'b0}}, d_reg} * {{DATA_W{1'b0}}, act_gain_reg[gi]};
                    out_reg <= (|shifted[SW-1:DATA_W]) ? '1 : shifted[DATA_W-1:0];
                end
            end

            assign run_min_flat[gi*DATA_W +: DATA_W] = run_min_reg;
            assign run_max_flat[gi*DATA_W +: DATA_W] = run_max_reg;
            assign stat_min[gi*DATA_W +: DATA_W]     = stat_min_reg;
            assign stat_max[gi*DATA_W +: DATA_W]     = stat_max_reg;
            assign data_out[gi*DATA_W +: DATA_W]     = out_reg;
        end
    endgenerate

    // Window of the channel currently owned by the divider
    always_comb begin
        cur_min = '0;
        cur_max = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (ch_reg == CHW'(c)) begin
                cur_min = win_min_reg[c];
                cur_max = win_max_reg[c];
            end
        end
    end

    // One restoring step; a zero final remainder means the quotient is already the ceiling
    assign cur_ident = (cur_max <= cur_min);
    assign divisor   = cur_max - cur_min;
    assign rem_sh    = {rem_reg, dvd_reg[GW-1]};
    assign ge        = (rem_sh >= {1'b0, divisor});
    assign rem_nx    = ge ? (rem_sh[DATA_W-1:0] - divisor) : rem_sh[DATA_W-1:0];
    assign quo_nx    = GW'({quo_reg, ge});
    assign gain_ceil = quo_nx + {{(GW-1){1'b0}}, |rem_nx};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            busy_reg       <= 1'b0;
            skip_pulse_reg <= 1'b0;
            skip_flag_reg  <= 1'b0;
            ch_reg         <= '0;
            cnt_reg        <= '0;
            rem_reg        <= '0;
            quo_reg        <= '0;
            dvd_reg        <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                win_min_reg[c]     <= '0;
                win_max_reg[c]     <= '0;
                shadow_min_reg[c]  <= '0;
                shadow_gain_reg[c] <= GAIN_ONE;
                act_min_reg[c]     <= '0;
                act_gain_reg[c]    <= GAIN_ONE;
            end
        end else begin
            skip_pulse_reg <= 1'b0;
            if (vs_rise) begin
                // A new frame edge always restarts the computation from channel 0
                skip_flag_reg <= 1'b0;
                ch_reg        <= '0;
                cnt_reg       <= '0;
                rem_reg       <= '0;
                quo_reg       <= '0;
                dvd_reg       <= DIVIDEND;
                for (int c = 0; c < CHANNELS; c++) begin
                    win_min_reg[c] <= (cfg_mode == 2'd2) ? cfg_min : run_min_flat[c*DATA_W +: DATA_W];
                    win_max_reg[c] <= (cfg_mode == 2'd2) ? cfg_max : run_max_flat[c*DATA_W +: DATA_W];
                end
                if (cfg_mode == 2'd1 || cfg_mode == 2'd2) begin
                    state_reg <= ST_DIV;
                    busy_reg  <= 1'b1;
                end else begin
                    state_reg <= ST_COMMIT;
                    busy_reg  <= 1'b0;
                    for (int c = 0; c < CHANNELS; c++) begin
                        shadow_min_reg[c]  <= '0;
                        shadow_gain_reg[c] <= GAIN_ONE;
                    end
                end
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    ST_DIV: begin
                        rem_reg <= rem_nx;
                        quo_reg <= quo_nx;
                        dvd_reg <= dvd_reg << 1;
                        cnt_reg <= cnt_reg + 1'b1;
                        if (pre.valid) skip_flag_reg <= 1'b1;
                        if (cnt_reg == LAST_BIT) begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (ch_reg == CHW'(c)) begin
                                    shadow_min_reg[c]  <= cur_ident ? '0 : cur_min;
                                    shadow_gain_reg[c] <= cur_ident ? GAIN_ONE : gain_ceil;
                                end
                            end
                            if (ch_reg == LAST_CH) begin
                                state_reg      <= ST_COMMIT;
                                busy_reg       <= 1'b0;
                                skip_pulse_reg <= skip_flag_reg | pre.valid;
                                skip_flag_reg  <= skip_flag_reg | pre.valid;
                            end else begin
                                ch_reg  <= ch_reg + 1'b1;
                                cnt_reg <= '0;
                                rem_reg <= '0;
                                quo_reg <= '0;
                                dvd_reg <= DIVIDEND;
                            end
                        end
                    end
                    ST_COMMIT: begin
                        if (!skip_flag_reg) begin
                            for (int c = 0; c < CHANNELS; c++) begin
                                act_min_reg[c]  <= shadow_min_reg[c];
                                act_gain_reg[c] <= shadow_gain_reg[c];
                            end
                        end
                        skip_flag_reg <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign gain_busy  = busy_reg;
    assign frame_skip = skip_pulse_reg;

endmodule

// File: tb/tb_contrast_stretch_stream.sv
// Randomised scoreboard bench for contrast_stretch_stream with three channels: a frame-level
// model predicts each stretched pixel, snapshot statistics, divider busy time and skip pulses.
module tb_contrast_stretch_stream;
    localparam int DW = 8;
    localparam int CH = 3;
    localparam int FR = 8;
    localparam int WW = DW * CH;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      cfg_mode = '0;
    logic [DW-1:0]   cfg_min = '0;
    logic [DW-1:0]   cfg_max = '0;
    logic [WW-1:0]   stat_min;
    logic [WW-1:0]   stat_max;
    logic            gain_busy;
    logic            frame_skip;

    contrast_stretch_stream_if #(.DATA_W(DW), .CHANNELS(CH)) pre_if ();
    contrast_stretch_stream_if #(.DATA_W(DW), .CHANNELS(CH)) post_if ();

    contrast_stretch_stream #(.DATA_W(DW), .CHANNELS(CH), .FRAC(FR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_mode   (cfg_mode),
        .cfg_min    (cfg_min),
        .cfg_max    (cfg_max),
        .pre        (pre_if),
        .post       (post_if),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .gain_busy  (gain_busy),
        .frame_skip (frame_skip)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];
    int   busy_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   exp_skips = 0;
    int   exp_frames = 0;
    int   skips_seen = 0;
    int   vs_rises_seen = 0;
    int   busy_len = 0;
    logic post_vs_d = 1'b0;

    // Reference model state: active window per channel and running/snapshot frame stats
    int m_act_min[CH];
    int m_act_gain[CH];
    int m_run_min[CH];
    int m_run_max[CH];
    int m_snap_min[CH];
    int m_snap_max[CH];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [WW-1:0] model_out(input logic [WW-1:0] w);
        logic [WW-1:0] r;
        r = '0;
        for (int c = 0; c < CH; c++) begin
            int x, d, o;
            x = int'(w[c*DW +: DW]);
            d = (x > m_act_min[c]) ? x - m_act_min[c] : 0;
            o = (d * m_act_gain[c]) / 256;
            if (o > 255) o = 255;
            r[c*DW +: DW] = o[DW-1:0];
        end
        return r;
    endfunction

    task automatic model_stats(input logic [WW-1:0] w);
        for (int c = 0; c < CH; c++) begin
            int x;
            x = int'(w[c*DW +: DW]);
            if (x < m_run_min[c]) m_run_min[c] = x;
            if (x > m_run_max[c]) m_run_max[c] = x;
        end
    endtask

    task automatic model_edge(input int mode, input int cmin, input int cmax, input bit skip);
        for (int c = 0; c < CH; c++) begin
            int lo, hi;
            m_snap_min[c] = m_run_min[c];
            m_snap_max[c] = m_run_max[c];
            m_run_min[c]  = 255;
            m_run_max[c]  = 0;
            lo = (mode == 1) ? m_snap_min[c] : cmin;
            hi = (mode == 1) ? m_snap_max[c] : cmax;
            if (!skip) begin
                if ((mode == 1 || mode == 2) && hi > lo) begin
                    m_act_min[c]  = lo;
                    m_act_gain[c] = (255 * 256 + (hi - lo) - 1) / (hi - lo);
                end else begin
                    m_act_min[c]  = 0;
                    m_act_gain[c] = 256;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [WW-1:0] w);
        exp_t e;
        e.data = model_out(w);
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
    endtask

    task automatic send_pixel(input logic [WW-1:0] w);
        pre_if.valid = 1'b1;
        pre_if.hsync = 1'b1;
        pre_if.data  = w;
        push_exp(w);
        model_stats(w);
        tick();
        pre_if.valid = 1'b0;
        pre_if.hsync = 1'b0;
        pre_if.data  = WW'($urandom);
        if ($urandom_range(3, 0) == 0) tick();
    endtask

    task automatic start_frame(input int mode, input int cmin, input int cmax, input int blank,
                               input bit skip, input bit edge_pix, input logic [WW-1:0] edge_word);
        cfg_mode      = mode[1:0];
        cfg_min       = cmin[DW-1:0];
        cfg_max       = cmax[DW-1:0];
        pre_if.vsync  = 1'b1;
        if (edge_pix) begin
            pre_if.valid = 1'b1;
            pre_if.hsync = 1'b1;
            pre_if.data  = edge_word;
            push_exp(edge_word);
        end
        model_edge(mode, cmin, cmax, skip);
        if (edge_pix) model_stats(edge_word);
        if (mode == 1 || mode == 2) busy_q.push_back(CH * (DW + FR));
        if (skip) exp_skips++;
        exp_frames++;
        tick();
        pre_if.valid = 1'b0;
        pre_if.hsync = 1'b0;
        cfg_mode     = 2'($urandom_range(3, 0));
        cfg_min      = DW'($urandom);
        cfg_max      = DW'($urandom);
        for (int c = 0; c < CH; c++) begin
            chk("stat_min", 32'(stat_min[c*DW +: DW]), 32'(m_snap_min[c]));
            chk("stat_max", 32'(stat_max[c*DW +: DW]), 32'(m_snap_max[c]));
        end
        tick();
        pre_if.vsync = 1'b0;
        repeat (blank - 2) tick();
    endtask

    function automatic logic [WW-1:0] rnd_word(input int lo0, input int hi0, input int lo1,
                                               input int hi1, input int lo2, input int hi2);
        logic [WW-1:0] w;
        w[DW-1:0]      = DW'($urandom_range(hi0, lo0));
        w[2*DW-1:DW]   = DW'($urandom_range(hi1, lo1));
        w[3*DW-1:2*DW] = DW'($urandom_range(hi2, lo2));
        return w;
    endfunction

    // Monitor: pixel scoreboard, divider busy length, skip pulses and frame starts
    always @(negedge clk) begin
        if (rst_n) begin
            if (post_if.valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pixel: got data %0h with nothing expected", post_if.data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("pixel_data", 32'(post_if.data), 32'(e.data));
                    chk("pixel_cycle", 32'(cyc), 32'(e.cyc));
                    chk("pixel_hsync", 32'(post_if.hsync), 32'd1);
                end
            end
            if (gain_busy) begin
                busy_len++;
            end else if (busy_len > 0) begin
                if (busy_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_busy: got %0d busy cycles with none expected", busy_len);
                end else begin
                    chk("gain_busy_len", 32'(busy_len), 32'(busy_q.pop_front()));
                end
                busy_len = 0;
            end
            if (frame_skip) skips_seen++;
            if (post_if.vsync && !post_vs_d) vs_rises_seen++;
            post_vs_d = post_if.vsync;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WW-1:0] w;
        for (int c = 0; c < CH; c++) begin
            m_act_min[c]  = 0;
            m_act_gain[c] = 256;
            m_run_min[c]  = 255;
            m_run_max[c]  = 0;
            m_snap_min[c] = 0;
            m_snap_max[c] = 0;
        end
        pre_if.vsync = 1'b0;
        pre_if.hsync = 1'b0;
        pre_if.valid = 1'b0;
        pre_if.data  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_post_vsync", 32'(post_if.vsync), 32'd0);
        chk("rst_post_hsync", 32'(post_if.hsync), 32'd0);
        chk("rst_post_valid", 32'(post_if.valid), 32'd0);
        chk("rst_post_data", 32'(post_if.data), 32'd0);
        chk("rst_stat_min", 32'(stat_min), 32'd0);
        chk("rst_stat_max", 32'(stat_max), 32'd0);
        chk("rst_gain_busy", 32'(gain_busy), 32'd0);
        chk("rst_frame_skip", 32'(frame_skip), 32'd0);
        rst_n = 1'b1;
        repeat (4) tick();

        // Bypass ramp
        start_frame(0, 0, 0, 60, 1'b0, 1'b0, '0);
        for (int i = 0; i < 256; i++) begin
            w[DW-1:0]      = DW'(i);
            w[2*DW-1:DW]   = DW'(255 - i);
            w[3*DW-1:2*DW] = DW'(i ^ 8'h55);
            send_pixel(w);
        end

        // Auto: independent windows ch0 50..200, ch1 0..255, ch2 128..128
        start_frame(1, 0, 0, 60, 1'b0, 1'b0, '0);
        send_pixel({8'd128, 8'd0, 8'd50});
        send_pixel({8'd128, 8'd255, 8'd200});
        for (int i = 0; i < 100; i++) send_pixel(rnd_word(50, 200, 0, 255, 128, 128));

        // Auto applied: includes the 50/125/200/30 corner points on ch0
        start_frame(1, 0, 0, 60, 1'b0, 1'b0, '0);
        send_pixel({8'd128, 8'd7, 8'd50});
        send_pixel({8'd0, 8'd99, 8'd125});
        send_pixel({8'd255, 8'd200, 8'd200});
        send_pixel({8'd127, 8'd1, 8'd30});
        for (int i = 0; i < 80; i++) send_pixel(rnd_word(0, 255, 0, 255, 0, 255));

        // Manual window 16..235 with clamp and saturation points
        start_frame(2, 16, 235, 60, 1'b0, 1'b0, '0);
        send_pixel({8'd235, 8'd235, 8'd235});
        send_pixel({8'd16, 8'd16, 8'd16});
        send_pixel({8'd10, 8'd10, 8'd10});
        send_pixel({8'd250, 8'd250, 8'd250});
        for (int i = 0; i < 60; i++) send_pixel(rnd_word(0, 255, 0, 255, 0, 255));

        // Short blanking: pixels arrive while the divider runs, old gains stay
        start_frame(1, 0, 0, 5, 1'b1, 1'b0, '0);
        for (int i = 0; i < 60; i++) send_pixel(rnd_word(20, 180, 40, 90, 0, 255));

        // Flat frame
        start_frame(1, 0, 0, 60, 1'b0, 1'b0, '0);
        for (int i = 0; i < 50; i++) send_pixel({8'd77, 8'd77, 8'd77});

        // Identity after flat frame; a pixel coincides with the vsync rise
        start_frame(1, 0, 0, 60, 1'b0, 1'b1, {8'd77, 8'd200, 8'd3});
        for (int i = 0; i < 60; i++) send_pixel(rnd_word(0, 255, 0, 255, 0, 255));

        // Empty frame, then the next frame must be identity
        start_frame(1, 0, 0, 60, 1'b0, 1'b0, '0);
        start_frame(1, 0, 0, 60, 1'b0, 1'b0, '0);
        for (int i = 0; i < 40; i++) send_pixel(rnd_word(0, 255, 0, 255, 0, 255));

        // Mode 3 behaves as bypass
        start_frame(3, 40, 90, 60, 1'b0, 1'b0, '0);
        for (int i = 0; i < 30; i++) send_pixel(rnd_word(0, 255, 0, 255, 0, 255));

        repeat (10) tick();
        chk("pixels_drained", 32'(exp_q.size()), 32'd0);
        chk("busy_drained", 32'(busy_q.size()), 32'd0);
        chk("frame_skip_count", 32'(skips_seen), 32'(exp_skips));
        chk("post_vsync_frames", 32'(vs_rises_seen), 32'(exp_frames));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
